dma_priority_arbiter: RTL and testbench

- Per-request service arbiter for the 4-channel DMA controller.
- Qualifies hardware and software requests using the mask, request and command register fields.
- Raises HRQ to the CPU and resolves fixed or rotating priority once HLDA is granted.
- Drives polarity-corrected DACK for the winning channel and holds it per that channel's mode until release; the transfer timing FSM consumes ActiveChannel/ChannelActive.

---
 rtl/dma_arbiter_pkg.sv | 18 +
 rtl/dma_priority_resolver.sv | 28 ++
 rtl/dma_priority_arbiter.sv | 144 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arbiter_pkg.sv
// Shared types and constants for the 4-channel DMA priority arbiter.
package dma_arbiter_pkg;

   localparam int NumChannels = 4;

   // Per-channel ModeSelect encodings.
   localparam logic [1:0] DEMAND  = 2'b00;
   localparam logic [1:0] SINGLE  = 2'b01;
   localparam logic [1:0] BLOCK   = 2'b10;
   localparam logic [1:0] CASCADE = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational priority encoder: highest priority is channel `ptr`, then
// ptr+1, ... wrapping mod 4. Fixed priority is simply ptr = 0.
module dma_priority_resolver
   import dma_arbiter_pkg::*;
(
   input  logic [NumChannels-1:0] pend,
   input  logic [1:0]             ptr,
   output logic [1:0]             winner,
   output logic                   valid
);

   logic [1:0] idx;

   // Scan lowest to highest priority so the highest pending channel is written last.
   always_comb begin
      winner = 2'd0;
      valid  = 1'b0;
      idx    = 2'd0;
      for (int k = NumChannels - 1; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (pend[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Per-request service arbiter for the 4-channel DMA controller.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no hold requested; waiting for a qualified request
// REQUEST | HRQ raised, waiting for HLDA; winner picked when it arrives
// SERVICE | DACK driven for ActiveChannel until its mode releases it
module dma_priority_arbiter
   import dma_arbiter_pkg::*;
(
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [NumChannels-1:0]   DREQ,
   input  logic [NumChannels-1:0]   SoftwareRequest,
   input  logic [NumChannels-1:0]   ChannelMask,
   input  logic [2*NumChannels-1:0] ChannelMode,
   input  logic                     ControllerDisable,
   input  logic                     RotatingPriority,
   input  logic                     DREQSenseLow,
   input  logic                     DACKSenseHigh,
   input  logic                     HLDA,
   input  logic                     TransferDone,
   input  logic                     TerminalCount,
   output logic                     HRQ,
   output logic [NumChannels-1:0]   DACK,
   output logic [1:0]               ActiveChannel,
   output logic                     ChannelActive,
   output logic [NumChannels-1:0]   PendingRequest
);

   arb_state_e             state_q, state_d;
   logic [NumChannels-1:0] pend_q, pend_d;
   logic                   hrq_q, hrq_d;
   logic [1:0]             act_ch_q, act_ch_d;
   logic                   act_en_q, act_en_d;
   logic [1:0]             ptr_q, ptr_d;
   logic                   rot_q, rot_d;

   logic [1:0]             res_ptr;
   logic [1:0]             win_ch;
   logic                   win_vld;
   logic [1:0]             act_mode;
   logic                   release_now;
   logic [NumChannels-1:0] ack;

   assign pend_d   = ((DREQ ^ {NumChannels{DREQSenseLow}}) & ~ChannelMask) | SoftwareRequest;
   assign rot_d    = RotatingPriority;
   assign res_ptr  = RotatingPriority ? ptr_q : 2'd0;
   assign act_mode = ChannelMode[{act_ch_q, 1'b0} +: 2];

   dma_priority_resolver u_resolver (
      .pend   (pend_q),
      .ptr    (res_ptr),
      .winner (win_ch),
      .valid  (win_vld)
   );

   // Release condition for the channel in service, by its transfer mode.
   always_comb begin
      release_now = 1'b0;
      case (act_mode)
         SINGLE:  release_now = TransferDone;
         BLOCK:   release_now = TransferDone & TerminalCount;
         DEMAND:  release_now = (TransferDone & TerminalCount) | ~pend_q[act_ch_q];
         CASCADE: release_now = ~pend_q[act_ch_q];
         default: release_now = 1'b0;
      endcase
   end

   // Next-state, hold request, grant and rotation pointer.
   always_comb begin
      state_d  = state_q;
      hrq_d    = hrq_q;
      act_ch_d = act_ch_q;
      act_en_d = act_en_q;
      ptr_d    = ptr_q;
      case (state_q)
         IDLE: begin
            if ((|pend_q) && !ControllerDisable) begin
               hrq_d   = 1'b1;
               state_d = REQUEST;
            end
         end
         REQUEST: begin
            if (ControllerDisable || !win_vld) begin
               hrq_d   = 1'b0;
               state_d = IDLE;
            end else if (HLDA) begin
               act_ch_d = win_ch;
               act_en_d = 1'b1;
               state_d  = SERVICE;
            end
         end
         SERVICE: begin
            // Losing HLDA is an abort, so the pointer is left alone.
            if (!HLDA) begin
               hrq_d    = 1'b0;
               act_en_d = 1'b0;
               state_d  = IDLE;
            end else if (release_now) begin
               hrq_d    = 1'b0;
               act_en_d = 1'b0;
               state_d  = IDLE;
               if (RotatingPriority) ptr_d = act_ch_q + 2'd1;
            end
         end
         default: begin
            hrq_d    = 1'b0;
            act_en_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
      if (rot_q && !RotatingPriority) ptr_d = 2'd0;
   end

   // State and request registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         hrq_q    <= 1'b0;
         act_ch_q <= 2'd0;
         act_en_q <= 1'b0;
         ptr_q    <= 2'd0;
         rot_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         hrq_q    <= hrq_d;
         act_ch_q <= act_ch_d;
         act_en_q <= act_en_d;
         ptr_q    <= ptr_d;
         rot_q    <= rot_d;
      end
   end

   assign ack            = act_en_q ? (4'b0001 << act_ch_q) : 4'b0000;
   assign DACK           = DACKSenseHigh ? ack : ~ack;
   assign HRQ            = hrq_q;
   assign ActiveChannel  = act_ch_q;
   assign ChannelActive  = act_en_q;
   assign PendingRequest = pend_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: expected grant channels are queued when
// requests are driven and popped when the DUT enters service.
`timescale 1ns/1ps
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic [3:0] DREQ = '0;
   logic [3:0] SoftwareRequest = '0;
   logic [3:0] ChannelMask = '0;
   logic [7:0] ChannelMode = 8'h55;
   logic       ControllerDisable = 1'b0;
   logic       RotatingPriority = 1'b0;
   logic       DREQSenseLow = 1'b0;
   logic       DACKSenseHigh = 1'b0;
   logic       HLDA = 1'b0;
   logic       TransferDone = 1'b0;
   logic       TerminalCount = 1'b0;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] ActiveChannel;
   logic       ChannelActive;
   logic [3:0] PendingRequest;

   int n_chk = 0;
   int n_fail = 0;
   int exp_q[$];

   dma_priority_arbiter dut (
      .CLK               (CLK),
      .RESET_N           (RESET_N),
      .DREQ              (DREQ),
      .SoftwareRequest   (SoftwareRequest),
      .ChannelMask       (ChannelMask),
      .ChannelMode       (ChannelMode),
      .ControllerDisable (ControllerDisable),
      .RotatingPriority  (RotatingPriority),
      .DREQSenseLow      (DREQSenseLow),
      .DACKSenseHigh     (DACKSenseHigh),
      .HLDA              (HLDA),
      .TransferDone      (TransferDone),
      .TerminalCount     (TerminalCount),
      .HRQ               (HRQ),
      .DACK              (DACK),
      .ActiveChannel     (ActiveChannel),
      .ChannelActive     (ChannelActive),
      .PendingRequest    (PendingRequest)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] idle_dack();
      return DACKSenseHigh ? 4'h0 : 4'hF;
   endfunction

   function automatic logic [3:0] dack_for(input int ch);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[ch] = 1'b1;
      return DACKSenseHigh ? oh : ~oh;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Wait for HRQ, answer with HLDA two cycles later, then score the grant.
   task automatic do_grant(input string tag);
      int cnt;
      int exp;
      cnt = 0;
      while (!HRQ && cnt < 50) begin
         tick(1);
         cnt++;
      end
      check_eq({tag, "_hrq"}, 32'(HRQ), 1);
      if (!HRQ) return;
      tick(2);
      HLDA = 1'b1;
      cnt = 0;
      while (!ChannelActive && cnt < 10) begin
         tick(1);
         cnt++;
      end
      check_eq({tag, "_active"}, 32'(ChannelActive), 1);
      check_eq({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      exp = exp_q.pop_front();
      check_eq({tag, "_ch"}, 32'(ActiveChannel), exp);
      check_eq({tag, "_dack"}, 32'(DACK), 32'(dack_for(exp)));
   endtask

   task automatic pulse_done(input logic tc);
      TransferDone  = 1'b1;
      TerminalCount = tc;
      tick(1);
      TransferDone  = 1'b0;
      TerminalCount = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 RESET_N = 1'b0;
      tick(3);
      check_eq("rst_hrq", 32'(HRQ), 0);
      check_eq("rst_dack", 32'(DACK), 32'hF);
      check_eq("rst_act", 32'(ChannelActive), 0);
      check_eq("rst_ch", 32'(ActiveChannel), 0);
      check_eq("rst_pend", 32'(PendingRequest), 0);
      RESET_N = 1'b1;
      tick(2);

      // Fixed priority: ch1 beats ch3, then ch3.
      ChannelMode = 8'h55;
      DREQ = 4'b1010;
      exp_q.push_back(1);
      exp_q.push_back(3);
      tick(1);
      check_eq("lat_hrq_1cyc", 32'(HRQ), 0);
      check_eq("lat_pend", 32'(PendingRequest), 32'b1010);
      tick(1);
      check_eq("lat_hrq_2cyc", 32'(HRQ), 1);
      do_grant("fix_a");
      tick(3);
      check_eq("single_hold", 32'(ChannelActive), 1);
      DREQ = 4'b1000;
      pulse_done(1'b0);
      check_eq("single_rel_act", 32'(ChannelActive), 0);
      check_eq("single_rel_hrq", 32'(HRQ), 0);
      check_eq("single_rel_dack", 32'(DACK), 32'(idle_dack()));
      HLDA = 1'b0;
      do_grant("fix_b");
      DREQ = 4'b0000;
      pulse_done(1'b0);
      HLDA = 1'b0;
      tick(3);

      // Rotating priority with all channels requesting.
      RotatingPriority = 1'b1;
      DREQ = 4'hF;
      foreach (exp_q[i]) ;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      for (int i = 0; i < 5; i++) begin
         do_grant("rot");
         if (i == 4) DREQ = 4'b0000;
         pulse_done(1'b0);
         HLDA = 1'b0;
      end
      tick(3);
      check_eq("rot_quiet", 32'(HRQ), 0);

      // Falling edge of RotatingPriority resets the pointer (it is 1 here).
      RotatingPriority = 1'b0;
      tick(2);
      RotatingPriority = 1'b1;
      DREQ = 4'b0011;
      exp_q.push_back(0);
      do_grant("rot_fall");
      DREQ = 4'b0000;
      pulse_done(1'b0);
      HLDA = 1'b0;
      tick(2);
      RotatingPriority = 1'b0;
      tick(2);

      // Block mode on ch2: held until TransferDone with TerminalCount.
      ChannelMode = 8'b01_10_01_01;
      DREQ = 4'b0100;
      exp_q.push_back(2);
      do_grant("blk");
      ControllerDisable = 1'b1;
      pulse_done(1'b0);
      check_eq("blk_xfer1", 32'(ChannelActive), 1);
      ControllerDisable = 1'b0;
      pulse_done(1'b0);
      check_eq("blk_xfer2", 32'(ChannelActive), 1);
      TerminalCount = 1'b1;
      tick(1);
      TerminalCount = 1'b0;
      check_eq("blk_tc_only", 32'(ChannelActive), 1);
      DREQ = 4'b0000;
      pulse_done(1'b1);
      check_eq("blk_rel", 32'(ChannelActive), 0);
      check_eq("blk_rel_dack", 32'(DACK), 32'(idle_dack()));
      HLDA = 1'b0;
      tick(2);

      // Demand mode on ch2: DREQ dropped with the first transfer.
      ChannelMode = 8'b01_00_01_01;
      DREQ = 4'b0100;
      exp_q.push_back(2);
      do_grant("dem");
      DREQ = 4'b0000;
      pulse_done(1'b0);
      check_eq("dem_wait", 32'(ChannelActive), 1);
      tick(1);
      check_eq("dem_rel", 32'(ChannelActive), 0);
      HLDA = 1'b0;
      tick(2);

      // Sense inversion, masking, software request, high-active DACK.
      ChannelMode = 8'h55;
      DACKSenseHigh = 1'b1;
      DREQSenseLow = 1'b1;
      DREQ = 4'b1110;
      ChannelMask = 4'b0001;
      tick(5);
      check_eq("mask_hrq", 32'(HRQ), 0);
      check_eq("mask_pend", 32'(PendingRequest), 0);
      check_eq("dack_idle_hi", 32'(DACK), 0);
      SoftwareRequest = 4'b0001;
      exp_q.push_back(0);
      do_grant("swreq");
      check_eq("swreq_pend", 32'(PendingRequest), 32'b0001);
      SoftwareRequest = 4'b0000;
      pulse_done(1'b0);
      HLDA = 1'b0;
      DREQ = 4'b0000;
      DREQSenseLow = 1'b0;
      ChannelMask = 4'b0000;
      DACKSenseHigh = 1'b0;
      tick(3);

      // ControllerDisable blocks new requests from IDLE.
      ControllerDisable = 1'b1;
      DREQ = 4'b0001;
      tick(4);
      check_eq("cd_idle_hrq", 32'(HRQ), 0);
      DREQ = 4'b0000;
      tick(2);
      ControllerDisable = 1'b0;
      tick(2);

      // Cascade on ch3: TransferDone ignored, released when DREQ drops.
      ChannelMode = 8'b11_01_01_01;
      DREQ = 4'b1000;
      exp_q.push_back(3);
      do_grant("cas");
      pulse_done(1'b1);
      check_eq("cas_done_ign", 32'(ChannelActive), 1);
      DREQ = 4'b0000;
      tick(1);
      check_eq("cas_wait", 32'(ChannelActive), 1);
      tick(1);
      check_eq("cas_rel", 32'(ChannelActive), 0);
      check_eq("cas_rel_dack", 32'(DACK), 32'hF);
      HLDA = 1'b0;
      tick(2);

      // HLDA abort leaves the rotation pointer unchanged.
      ChannelMode = 8'h55;
      RotatingPriority = 1'b1;
      DREQ = 4'hF;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(1);
      do_grant("abort_a");
      HLDA = 1'b0;
      tick(1);
      check_eq("abort_act", 32'(ChannelActive), 0);
      check_eq("abort_hrq", 32'(HRQ), 0);
      do_grant("abort_b");
      pulse_done(1'b0);
      HLDA = 1'b0;
      do_grant("abort_c");
      DREQ = 4'b0000;
      pulse_done(1'b0);
      HLDA = 1'b0;
      tick(2);

      // Asynchronous reset in the middle of a service.
      RotatingPriority = 1'b0;
      DREQ = 4'b0100;
      exp_q.push_back(2);
      do_grant("rst_mid");
      #2 RESET_N = 1'b0;
      #1;
      check_eq("rst_mid_hrq", 32'(HRQ), 0);
      check_eq("rst_mid_dack", 32'(DACK), 32'hF);
      check_eq("rst_mid_act", 32'(ChannelActive), 0);
      check_eq("rst_mid_ch", 32'(ActiveChannel), 0);
      DREQ = 4'b0000;
      HLDA = 1'b0;
      tick(2);
      RESET_N = 1'b1;
      tick(2);
      check_eq("post_rst_pend", 32'(PendingRequest), 0);

      check_eq("sb_drain", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
